// File: rtl/debounce_ctrl_if.sv
// rtl/debounce_ctrl_if.sv - switch input, timer handshake and debounced outputs of debounce_ctrl
interface debounce_ctrl_if;
  logic sw_in;
  logic tick;
  logic timer_rst;
  logic db_level;
  logic db_rise;
  logic db_fall;
  logic busy;

  modport master (
    output sw_in, tick,
    input  timer_rst, db_level, db_rise, db_fall, busy
  );

  modport slave (
    input  sw_in, tick,
    output timer_rst, db_level, db_rise, db_fall, busy
  );
endinterface

// File: rtl/debounce_ctrl.sv
// rtl/debounce_ctrl.sv - debounces one switch by counting external timer ticks while the new level holds
module debounce_ctrl #(
  parameter int N_TICKS     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  debounce_ctrl_if.slave  bus
);

  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] ONE   = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(N_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic [1:0]             state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   level_q, rise_q, fall_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sw_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // A level change back to the stable state always beats a coincident tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (sync_in) state_nxt = WAIT1;
      end
      WAIT1: begin
        if (!sync_in) begin
          state_nxt = ZERO;
        end else if (bus.tick) begin
          if (cnt == LAST_CNT) state_nxt = ONE;
          else                 cnt_nxt   = cnt + 4'd1;
        end
      end
      ONE: begin
        if (!sync_in) state_nxt = WAIT0;
      end
      WAIT0: begin
        if (sync_in) begin
          state_nxt = ONE;
        end else if (bus.tick) begin
          if (cnt == LAST_CNT) state_nxt = ZERO;
          else                 cnt_nxt   = cnt + 4'd1;
        end
      end
      default: state_nxt = ZERO;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ZERO;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= (state_nxt == ONE) || (state_nxt == WAIT0);
      rise_q  <= (state == WAIT1) && (state_nxt == ONE);
      fall_q  <= (state == WAIT0) && (state_nxt == ZERO);
      busy_q  <= (state_nxt == WAIT1) || (state_nxt == WAIT0);
    end
  end

  // Timer is held cleared in the stable states so each WAIT starts a full period.
  assign bus.timer_rst = (state == ZERO) || (state == ONE);
  assign bus.db_level  = level_q;
  assign bus.db_rise   = rise_q;
  assign bus.db_fall   = fall_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// tb/tb_debounce_ctrl.sv - table, corner-case and random checks of debounce_ctrl against a level/candidate model
module tb_debounce_ctrl;

  logic clk;
  logic reset;
  logic sw;
  logic tk;

  debounce_ctrl_if bus_a ();
  debounce_ctrl_if bus_b ();

  assign bus_a.sw_in = sw;
  assign bus_a.tick  = tk;
  assign bus_b.sw_in = sw;
  assign bus_b.tick  = tk;

  debounce_ctrl u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  debounce_ctrl #(.N_TICKS(1), .SYNC_STAGES(3)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {timer_rst, db_level, db_rise, db_fall, busy}
  logic [4:0] vec_a, vec_b;
  assign vec_a = {bus_a.timer_rst, bus_a.db_level, bus_a.db_rise, bus_a.db_fall, bus_a.busy};
  assign vec_b = {bus_b.timer_rst, bus_b.db_level, bus_b.db_rise, bus_b.db_fall, bus_b.busy};

  int tests = 0;
  int fails = 0;

  // Model: accepted level, whether a candidate is pending, and ticks survived by it.
  typedef struct {
    logic [3:0] hist;
    bit         lvl;
    bit         qual;
    int         ticks;
    bit         rise;
    bit         fall;
    int         stages;
    int         n;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(model_t m, bit r, bit s, bit t);
    bit seen;
    m.rise = 1'b0;
    m.fall = 1'b0;
    if (r) begin
      m.hist  = '0;
      m.lvl   = 1'b0;
      m.qual  = 1'b0;
      m.ticks = 0;
      return m;
    end
    seen   = m.hist[m.stages-1];
    m.hist = {m.hist[2:0], s};
    if (!m.qual) begin
      if (seen != m.lvl) begin
        m.qual  = 1'b1;
        m.ticks = 0;
      end
    end else if (seen == m.lvl) begin
      m.qual = 1'b0;
    end else if (t) begin
      m.ticks++;
      if (m.ticks == m.n) begin
        m.lvl  = seen;
        m.qual = 1'b0;
        m.rise = seen;
        m.fall = !seen;
      end
    end
    return m;
  endfunction

  function automatic logic [4:0] model_vec(model_t m);
    return {!m.qual, m.lvl, m.rise, m.fall, m.qual};
  endfunction

  task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit t);
    reset = r;
    sw    = s;
    tk    = t;
    @(posedge clk);
    ma = model_step(ma, r, s, t);
    mb = model_step(mb, r, s, t);
    #1;
    cmp("model_a", vec_a, model_vec(ma));
    cmp("model_b", vec_b, model_vec(mb));
  endtask

  task automatic hold_until_busy(input bit s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, s, 1'b0);
      if (bus_a.busy) begin
        ok = 1'b1;
        break;
      end
    end
    cmp("wait_busy", {4'b0, ok}, 5'b00001);
  endtask

  typedef struct packed {
    bit         r;
    bit         s;
    bit         t;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [23];

  initial begin
    ma = '{hist: '0, lvl: 0, qual: 0, ticks: 0, rise: 0, fall: 0, stages: 2, n: 3};
    mb = '{hist: '0, lvl: 0, qual: 0, ticks: 0, rise: 0, fall: 0, stages: 3, n: 1};
    reset = 1'b1;
    sw    = 1'b0;
    tk    = 1'b0;

    // Reset with sw high, press, bounce inside WAIT0, then clean release.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'b10000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'b10000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'b00001};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'b00001};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'b00001};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'b00001};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'b11100};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'b11000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 5'b11000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'b01001};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 5'b01001};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 5'b01001};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 5'b01001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 5'b01001};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 5'b01001};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 5'b01001};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 5'b10010};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 5'b10000};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].t);
      cmp($sformatf("tbl[%0d]", i), vec_a, tbl[i].exp);
    end

    // Tick arrives on the same edge the level bounces back, with cnt at N_TICKS-1.
    step(1'b1, 1'b0, 1'b0);
    hold_until_busy(1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    cmp("collision", vec_a, 5'b10000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      cmp("collision_no_rise", {4'b0, bus_a.db_rise}, 5'b0);
    end

    // Reset one cycle after two ticks in WAIT0.
    hold_until_busy(1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    cmp("press", vec_a, 5'b11100);
    hold_until_busy(1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    cmp("rst_wait0", vec_a, 5'b10000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      cmp("rst_wait0_no_fall", {4'b0, bus_a.db_fall}, 5'b0);
    end

    // Random bouncing input, sparse ticks and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, t;
      r = ($urandom_range(199) == 0);
      s = ($urandom_range(11) == 0) ? !sw : sw;
      t = ($urandom_range(3) == 0);
      step(r, s, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
- FSM controller that sequences the periodic-tick timer datapath to debounce one mechanical switch input.
- Synchronises the raw input and holds the timer in reset while the input is stable.
- Releases the timer when the input changes, and counts consecutive timer ticks during which the new level holds.
- Emits a clean level plus one-cycle rise/fall pulses. Sits between the pad input and the user logic; the timer instance is external.

Parameters:
- N_TICKS, 3, consecutive timer ticks the new level must hold before acceptance; legal 1..15.
- SYNC_STAGES, 2, flip-flops in the input synchroniser; legal 2..4.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- sw_in  input  1  raw asynchronous switch level.
- tick  input  1  done pulse from timer datapath, one cycle wide.
- timer_rst  output  1  reset to the timer datapath; high holds the timer count at 0.
- db_level  output  1  debounced level, registered.
- db_rise  output  1  one-cycle pulse on accepted 0->1.
- db_fall  output  1  one-cycle pulse on accepted 1->0.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Reset is synchronous, active-high, clock is clk. During reset:
  - synchroniser flops, state and tick counter clear: state=ZERO, cnt=0.
  - db_level=0, db_rise=0, db_fall=0, busy=0, timer_rst=1.
- sync_in = sw_in delayed by SYNC_STAGES clk edges. The FSM sees only sync_in, never sw_in.
- States: ZERO, WAIT1, ONE, WAIT0. cnt is 4 bits and clears on every state change.
- ZERO: sync_in=1 -> WAIT1; else stay.
- WAIT1:
  - sync_in=0 -> ZERO (bounce, candidate rejected, no pulse).
  - else tick=1 and cnt==N_TICKS-1 -> ONE.
  - else tick=1 -> cnt+1.
  - else hold.
- ONE: sync_in=0 -> WAIT0; else stay.
- WAIT0: mirror of WAIT1 with levels inverted. sync_in=1 -> ONE; qualification complete -> ZERO.
- Simultaneous tick and bounce in a WAIT state: bounce wins; return to the stable state, no acceptance.
- timer_rst: combinational, = 1 in ZERO and ONE, = 0 in WAIT1 and WAIT0.
  - The timer therefore starts from count 0 on the first WAIT cycle.
  - The first tick arrives a full timer period after WAIT entry.
- tick is ignored in ZERO and ONE.
- db_level:
  - registered; 0 in ZERO/WAIT1, 1 in ONE/WAIT0.
  - changes on the same edge the state enters ONE or ZERO from a WAIT state.
- db_rise: registered, high exactly the cycle after the WAIT1->ONE edge, i.e. coincident with db_level first reading 1. db_fall is symmetric. Never both high.
- busy = state is WAIT1 or WAIT0, registered with the state.
- Latency:
  - stable sw_in change to WAIT entry: SYNC_STAGES+1 edges.
  - WAIT entry to acceptance: N_TICKS ticks plus one edge.
- Reset mid-qualification: returns to ZERO with db_level=0 regardless of sw_in. If sw_in is held 1, a fresh qualification follows with a rise pulse.
- N_TICKS=1: first tick in WAIT accepts.
- cnt never exceeds N_TICKS-1; no wrap possible.

Test Plan:
- Reset behaviour:
  - Stimulus: reset high 3 cycles, sw_in=1.
  - Required: db_level=0, db_rise=db_fall=0, busy=0, timer_rst=1 throughout.
  - Required after release: state reaches WAIT1 at SYNC_STAGES+1 edges.
- Clean press:
  - Stimulus: sw_in 0->1 held; tick pulsed every 20 cycles while timer_rst=0; N_TICKS=3.
  - Required: busy high from WAIT entry; db_level=1 and db_rise single pulse the cycle after the 3rd tick; timer_rst returns to 1; busy=0.
- Bounce:
  - Stimulus: sw_in toggles 1,0,1,0 every 5 cycles, then stays 0.
  - Required: busy pulses, db_level stays 0, no db_rise, no tick counted across bounces.
- Tick/bounce collision:
  - Stimulus: in WAIT1 with cnt=2, tick=1 in the same cycle sync_in falls to 0.
  - Required: state ZERO, db_rise never asserted.
- Clean release:
  - Stimulus: from ONE, sw_in 1->0 held with periodic ticks.
  - Required: db_fall single pulse, db_level=0 after the 3rd tick; db_rise stays 0.
- Reset in WAIT0:
  - Stimulus: assert reset for 1 cycle after 2 ticks in WAIT0, sw_in held 0.
  - Required: db_level=0 immediately after reset, no db_fall pulse, state ZERO, timer_rst=1.
